// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the BCD digit scanner:
//   - state_e      : handshake FSM states (IDLE, CONVERT, LOAD)
//   - BCD_W        : bits per BCD digit
//   - BCD_ADD3_TH  : digit value at or above which double-dabble adds 3
//   - bcd_adjust() : per-digit add-3 correction applied before each shift
// ---------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_e;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] BCD_ADD3_TH = 4'd5;

    // A digit >= 5 would become >= 10 after doubling; adding 3 first
    // turns that doubling into a clean carry into the next digit.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] nib);
        logic [BCD_W-1:0] res;
        if (nib >= BCD_ADD3_TH) begin
            res = nib + BCD_W'(3);
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// ---------------------------------------------------------------------------
// bcd_double_dabble
// Sequential shift-and-add-3 binary to BCD converter, one input bit per cycle.
// A start pulse loads the binary value and clears the BCD accumulator; the
// following BIN_WIDTH cycles each adjust every digit then shift {bcd,bin}
// left by one. BCD bits shifted out of the top digit are dropped, so the
// result is the input modulo 10^NUM_DIGITS.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous reset, active low
//   i_start    in   load i_data and begin a conversion
//   i_data     in   BIN_WIDTH binary value
//   o_done     out  high during the cycle whose closing edge does the last shift
//   o_bcd      out  NUM_DIGITS*4 BCD accumulator, digit 0 in the low nibble
// ---------------------------------------------------------------------------
module bcd_double_dabble
    import display_pkg::*;
#(
    parameter int BIN_WIDTH  = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          i_start,
    input  logic [BIN_WIDTH-1:0]          i_data,
    output logic                          o_done,
    output logic [NUM_DIGITS*BCD_W-1:0]   o_bcd
);

    localparam int BCD_TOT = NUM_DIGITS * BCD_W;
    localparam int CNT_W   = $clog2(BIN_WIDTH + 1);

    logic [BIN_WIDTH-1:0]         r_bin;
    logic [BCD_TOT-1:0]           r_bcd;
    logic [CNT_W-1:0]             r_cnt;
    logic [BCD_TOT-1:0]           w_bcd_adj;
    logic [BCD_TOT+BIN_WIDTH-1:0] w_shifted;

    // Add-3 correction on every digit, then the combined left shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_bcd_adj[i*BCD_W +: BCD_W] = bcd_adjust(r_bcd[i*BCD_W +: BCD_W]);
        end
        w_shifted = {w_bcd_adj, r_bin} << 1'b1;
    end

    // Shift register, accumulator and remaining-bit counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_bin <= i_data;
            r_bcd <= '0;
            r_cnt <= CNT_W'(BIN_WIDTH);
        end else if (r_cnt != '0) begin
            r_bin <= w_shifted[BIN_WIDTH-1:0];
            r_bcd <= w_shifted[BCD_TOT+BIN_WIDTH-1:BIN_WIDTH];
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_bin <= r_bin;
            r_bcd <= r_bcd;
            r_cnt <= r_cnt;
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/bcd_digit_scanner.sv
// ---------------------------------------------------------------------------
// bcd_digit_scanner
// Accepts a binary reading, converts it to BCD and time-multiplexes the
// digits onto a 4-bit bus for a registered 7-segment decoder stage.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous reset, active low
//   data_valid     in   data_in valid this cycle
//   data_in        in   BIN_WIDTH unsigned value to display
//   data_ready     out  block is IDLE and will accept data_in
//   busy           out  conversion in progress
//   binary_number  out  BCD digit currently selected (to decoder input)
//   digit_enable   out  one-hot digit select, bit 0 = units, one cycle
//                       behind binary_number to match the decoder register
//
// Build option: define LEADING_ZERO_BLANK_EN to suppress digit_enable for
// leading zero digits (units digit always shown).
// ---------------------------------------------------------------------------
module bcd_digit_scanner
    import display_pkg::*;
#(
    parameter int BIN_WIDTH   = 16,
    parameter int NUM_DIGITS  = 5,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   data_valid,
    input  logic [BIN_WIDTH-1:0]   data_in,
    output logic                   data_ready,
    output logic                   busy,
    output logic [3:0]             binary_number,
    output logic [NUM_DIGITS-1:0]  digit_enable
);

    localparam int DISP_W = NUM_DIGITS * BCD_W;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RCNT_W = $clog2(REFRESH_DIV);

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  w_start;
    logic                  w_load;
    logic                  w_conv_done;
    logic [DISP_W-1:0]     w_bcd;
    logic [DISP_W-1:0]     r_display;
    logic [RCNT_W-1:0]     r_refresh_cnt;
    logic [IDX_W-1:0]      r_digit_idx;
    logic [BCD_W-1:0]      w_digit;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS-1:0] w_show;
    logic [NUM_DIGITS-1:0] r_en_pre;
    logic [NUM_DIGITS-1:0] r_digit_enable;
    logic [BCD_W-1:0]      r_binary_number;
    logic                  r_busy;
    logic                  r_data_ready;

    bcd_double_dabble #(
        .BIN_WIDTH  (BIN_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_dd (
        .clock   (clock),
        .reset_n (reset_n),
        .i_start (w_start),
        .i_data  (data_in),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    // Handshake FSM next-state and control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_valid) begin
                    w_state_nxt = CONVERT;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CONVERT: begin
                if (w_conv_done) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = CONVERT;
                end
            end
            LOAD: begin
                w_state_nxt = IDLE;
                w_load      = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register; status outputs are registered from the next state
    // so they always agree with the state they describe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_data_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt == CONVERT);
            r_data_ready <= (w_state_nxt == IDLE);
        end
    end

    // Display register: only a completed conversion ever reaches it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_display <= '0;
        end else if (w_load) begin
            r_display <= w_bcd;
        end else begin
            r_display <= r_display;
        end
    end

    // Refresh divider and digit index; free-running, never stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= '0;
        end else if (r_refresh_cnt == RCNT_W'(REFRESH_DIV - 1)) begin
            r_refresh_cnt <= '0;
            if (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                r_digit_idx <= '0;
            end else begin
                r_digit_idx <= r_digit_idx + IDX_W'(1);
            end
        end else begin
            r_refresh_cnt <= r_refresh_cnt + RCNT_W'(1);
            r_digit_idx   <= r_digit_idx;
        end
    end

    // Digit mux, one-hot select and the leading-zero visibility mask.
    always_comb begin
        w_digit  = r_display[BCD_W*r_digit_idx +: BCD_W];
        w_onehot = NUM_DIGITS'(1) << r_digit_idx;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic w_nz;
            w_nz   = 1'b0;
            w_show = '0;
            // Walk from the most significant digit down; once any non-zero
            // digit is seen, it and every lower digit are shown.
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                w_nz      = w_nz | (r_display[i*BCD_W +: BCD_W] != '0) | (i == 0);
                w_show[i] = w_nz;
            end
        end
`else
        w_show = '1;
`endif
    end

    // Output pipeline: digit value to the decoder now, matching select one
    // cycle later so it lines up with the decoder's registered segments.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_binary_number <= '0;
            r_en_pre        <= '0;
            r_digit_enable  <= '0;
        end else begin
            r_binary_number <= w_digit;
            r_en_pre        <= w_onehot & w_show;
            r_digit_enable  <= r_en_pre;
        end
    end

    assign data_ready    = r_data_ready;
    assign busy          = r_busy;
    assign binary_number = r_binary_number;
    assign digit_enable  = r_digit_enable;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_scanner
// Scoreboard bench: each accepted value pushes its expected digits and
// enable mask; when busy falls the entry is popped and one full scan period
// is compared digit by digit against the decoder-aligned outputs.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bcd_digit_scanner;

    localparam int BW = 16;
    localparam int ND = 5;
    localparam int RD = 4;

    logic          clock;
    logic          reset_n;
    logic          data_valid;
    logic [BW-1:0] data_in;
    logic          data_ready;
    logic          busy;
    logic [3:0]    binary_number;
    logic [ND-1:0] digit_enable;

    typedef struct packed {
        logic [ND-1:0][3:0] dig;
        logic [ND-1:0]      mask;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bcd_digit_scanner #(
        .BIN_WIDTH   (BW),
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_valid    (data_valid),
        .data_in       (data_in),
        .data_ready    (data_ready),
        .busy          (busy),
        .binary_number (binary_number),
        .digit_enable  (digit_enable)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t make_exp(input int unsigned v);
        exp_t        e;
        int unsigned m;
        int unsigned p;
        logic        nz;
        m  = v % 100000;
        p  = 1;
        nz = 1'b0;
        for (int i = 0; i < ND; i++) begin
            e.dig[i] = 4'((m / p) % 10);
            p        = p * 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = ND - 1; i >= 0; i--) begin
            nz        = nz | (e.dig[i] != 4'd0) | (i == 0);
            e.mask[i] = nz;
        end
`else
        e.mask = '1;
`endif
        return e;
    endfunction

    task automatic send_value(input int unsigned v);
        @(negedge clock);
        check_eq("ready_before_send", 32'(data_ready), 32'd1);
        data_valid = 1'b1;
        data_in    = 16'(v);
        sb_q.push_back(make_exp(v));
        @(posedge clock);
        #1;
        data_valid = 1'b0;
    endtask

    // One full refresh period: each shown digit must dwell RD cycles and the
    // select must pair with the digit value presented one cycle earlier.
    task automatic scan(input exp_t e);
        logic [3:0]    prev_bn;
        logic [ND-1:0] de;
        int            dwell[ND];
        for (int i = 0; i < ND; i++) dwell[i] = 0;
        prev_bn = binary_number;
        for (int c = 0; c < ND * RD; c++) begin
            @(negedge clock);
            de = digit_enable;
            if (de != '0) begin
                check_eq("de_onehot", 32'($onehot(de)), 32'd1);
                for (int i = 0; i < ND; i++) begin
                    if (de[i]) begin
                        dwell[i]++;
                        check_eq($sformatf("digit%0d", i), 32'(prev_bn), 32'(e.dig[i]));
                    end
                end
            end
            prev_bn = binary_number;
        end
        for (int i = 0; i < ND; i++) begin
            check_eq($sformatf("dwell%0d", i), 32'(dwell[i]), e.mask[i] ? 32'(RD) : 32'd0);
        end
    endtask

    task automatic wait_and_scan(input bit inject);
        int   cnt;
        bit   timed_out;
        exp_t e;
        cnt       = 0;
        timed_out = 1'b0;
        while (1'b1) begin
            @(negedge clock);
            if (inject && cnt == 5) begin
                data_valid = 1'b1;
                data_in    = 16'd11;
            end else begin
                data_valid = 1'b0;
            end
            if (!busy) break;
            cnt++;
            if (cnt > 40) begin
                timed_out = 1'b1;
                break;
            end
        end
        data_valid = 1'b0;
        check_eq("busy_timeout", 32'(timed_out), 32'd0);
        check_eq("busy_cycles", 32'(cnt), 32'd16);
        check_eq("ready_in_load", 32'(data_ready), 32'd0);
        @(negedge clock);
        check_eq("ready_after_load", 32'(data_ready), 32'd1);
        @(negedge clock);
        check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e = '0;
        end
        scan(e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        #22;
        check_eq("rst_ready", 32'(data_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_bn", 32'(binary_number), 32'd0);
        check_eq("rst_de", 32'(digit_enable), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("de_cycle1", 32'(digit_enable), 32'd0);
        check_eq("bn_cycle1", 32'(binary_number), 32'd0);
        @(negedge clock);
        check_eq("de_cycle2", 32'(digit_enable), 32'd1);

        send_value(1234);
        wait_and_scan(1'b0);
        send_value(65535);
        wait_and_scan(1'b1);
        send_value(42);
        wait_and_scan(1'b0);
        send_value(0);
        wait_and_scan(1'b0);
        send_value(100);
        wait_and_scan(1'b0);
        send_value(9);
        wait_and_scan(1'b0);
        for (int r = 0; r < 6; r++) begin
            send_value($urandom_range(0, 65535));
            wait_and_scan(1'b0);
        end

        // Reset in the middle of a conversion.
        send_value(9999);
        repeat (8) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_bn", 32'(binary_number), 32'd0);
        check_eq("midrst_de", 32'(digit_enable), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_ready", 32'(data_ready), 32'd1);
        sb_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        scan(make_exp(0));

        send_value(5);
        wait_and_scan(1'b0);

        check_eq("sb_final_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
